// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes and
// datapath mux/ALU select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StError    = 4'd11
    } ctrl_state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ImmI = 2'd0;
    localparam logic [1:0] ImmS = 2'd1;
    localparam logic [1:0] ImmB = 2'd2;
    localparam logic [1:0] ImmJ = 2'd3;

    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAOldPc = 2'd1;
    localparam logic [1:0] SrcARd1   = 2'd2;

    localparam logic [1:0] SrcBRd2  = 2'd0;
    localparam logic [1:0] SrcBImm  = 2'd1;
    localparam logic [1:0] SrcBFour = 2'd2;

    localparam logic [1:0] ResAluOut = 2'd0;
    localparam logic [1:0] ResData   = 2'd1;
    localparam logic [1:0] ResAlu    = 2'd2;

    localparam logic AdrPc     = 1'b0;
    localparam logic AdrResult = 1'b1;

endpackage

// File: rtl/riscv_alu_dec.sv
// Combinational ALU-op decode from {opcode, funct3, instr[30]}, flagging encodings the
// core does not implement.
module riscv_alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = AluAdd;
        illegal  = 1'b0;
        case (opcode)
            OpLoad, OpStore: illegal = (funct3 != 3'b010);
            OpBranch: begin
                alu_ctrl = AluSub;
                illegal  = (funct3 != 3'b000);
            end
            OpJal: illegal = 1'b0;
            OpRtype, OpItype: begin
                case (funct3)
                    // instr[30] selects sub only for register-register ops
                    3'b000:  alu_ctrl = (opcode == OpRtype && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alu_ctrl = AluSlt;
                    3'b110:  alu_ctrl = AluOr;
                    3'b111:  alu_ctrl = AluAnd;
                    default: illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_multi_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives
// every datapath control input; unsupported encodings park in a sticky error state.
module riscv_multi_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  imm_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  res_src,
    output logic        err,
    output logic [3:0]  state
);

    ctrl_state_e state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  dec_alu_ctrl;
    logic        dec_illegal;
    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign state        = state_q;

    riscv_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7b5 (instr[30]),
        .alu_ctrl (dec_alu_ctrl),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        adr_src   = AdrPc;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        imm_src   = ImmI;
        alu_src_a = SrcAPc;
        alu_src_b = SrcBRd2;
        alu_ctrl  = AluAdd;
        res_src   = ResAluOut;
        err       = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b = SrcBFour;
                res_src   = ResAlu;
                pc_we     = mem_ready;
                ir_we     = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // ALU precomputes old_pc + imm as the branch target
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (opcode)
                    OpStore:  imm_src = ImmS;
                    OpBranch: imm_src = ImmB;
                    OpJal:    imm_src = ImmJ;
                    default:  imm_src = ImmI;
                endcase
                if (dec_illegal) begin
                    state_d = StError;
                end else begin
                    case (opcode)
                        OpLoad, OpStore: state_d = StMemAdr;
                        OpRtype:         state_d = StExecR;
                        OpItype:         state_d = StExecI;
                        OpBranch:        state_d = StBeq;
                        OpJal:           state_d = StJal;
                        default:         state_d = StError;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBImm;
                imm_src   = (opcode == OpStore) ? ImmS : ImmI;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = AdrResult;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                res_src = ResData;
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StMemWrite: begin
                adr_src = AdrResult;
                mem_we  = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = SrcARd1;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBImm;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StBeq: begin
                alu_src_a = SrcARd1;
                alu_ctrl  = AluSub;
                pc_we     = zero;
                state_d   = StFetch;
            end
            StJal: begin
                // PC takes the target latched in DECODE; ALU forms PC+4 for rd
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_we     = 1'b1;
                state_d   = StAluWb;
            end
            StError: err = 1'b1;
            default: state_d = StError;
        endcase
        if (!rst) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            mem_we = 1'b0;
            reg_we = 1'b0;
            err    = 1'b0;
        end
    end

endmodule
